decode_stage_scoreboard: RTL

- Registered, handshaked successor to the single-cycle instruction control decoder; sits between fetch and execute.
- Decodes RV32I opcode class into memory, register-write and ALU-operand-source controls, and holds them in a one-entry valid/ready pipeline register.
- Adds a register scoreboard that detects read-after-write hazards against instructions still in flight and stalls issue until writeback clears them.
- Flags illegal opcodes instead of emitting don't-cares; supports a pipeline flush and keeps a saturating stall counter.

---
 rtl/decode_stage_scoreboard.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : decode_stage_scoreboard
// Desc   : RV32I control decode, valid/ready output register, RAW scoreboard
// Rev    : 1.0
// ============================================================================
module decode_stage_scoreboard #(
   parameter int XLEN        = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [XLEN-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [XLEN-1:0]        out_pc,
   output logic                   out_should_read_mem,
   output logic                   out_should_write_mem,
   output logic                   out_should_write_reg,
   output logic [REG_ADDR_W-1:0]  out_rs1_addr,
   output logic [REG_ADDR_W-1:0]  out_rs2_addr,
   output logic [REG_ADDR_W-1:0]  out_rd_addr,
   output logic [2:0]             out_alu_a_src,
   output logic [2:0]             out_alu_b_src,
   output logic                   out_illegal,
   input  logic                   wb_valid,
   input  logic [REG_ADDR_W-1:0]  wb_rd_addr,
   input  logic                   flush,
   output logic [STALL_CNT_W-1:0] stall_count
);
   localparam int NUM_REGS = 2**REG_ADDR_W;

   localparam logic [2:0] c_src_zero  = 3'd0;
   localparam logic [2:0] c_src_four  = 3'd1;
   localparam logic [2:0] c_src_pc    = 3'd2;
   localparam logic [2:0] c_src_reg   = 3'd3;
   localparam logic [2:0] c_src_imm12 = 3'd4;
   localparam logic [2:0] c_src_imm20 = 3'd5;

   localparam logic [4:0] c_op_load   = 5'h00;
   localparam logic [4:0] c_op_fence  = 5'h03;
   localparam logic [4:0] c_op_imm    = 5'h04;
   localparam logic [4:0] c_op_auipc  = 5'h05;
   localparam logic [4:0] c_op_store  = 5'h08;
   localparam logic [4:0] c_op_op     = 5'h0c;
   localparam logic [4:0] c_op_lui    = 5'h0d;
   localparam logic [4:0] c_op_branch = 5'h18;
   localparam logic [4:0] c_op_jalr   = 5'h19;
   localparam logic [4:0] c_op_jal    = 5'h1b;

   logic                   w_rd_mem, w_wr_mem, w_wr_reg, w_uses_rs1, w_uses_rs2, w_illegal;
   logic [2:0]             w_a_src, w_b_src;
   logic [REG_ADDR_W-1:0]  w_rs1, w_rs2, w_rd;
   logic                   w_rs1_hz, w_rs2_hz, w_hazard, w_load;
   logic [NUM_REGS-1:0]    r_pending, w_pending_nxt;

   logic                   r_out_valid, r_rd_mem, r_wr_mem, r_wr_reg, r_illegal;
   logic [31:0]            r_instr;
   logic [XLEN-1:0]        r_pc;
   logic [REG_ADDR_W-1:0]  r_rs1, r_rs2, r_rd;
   logic [2:0]             r_a_src, r_b_src;
   logic [STALL_CNT_W-1:0] r_stall_count;

   assign w_rs1 = in_instr[15 +: REG_ADDR_W];
   assign w_rs2 = in_instr[20 +: REG_ADDR_W];
   assign w_rd  = in_instr[7 +: REG_ADDR_W];

   always_comb begin
      w_rd_mem   = 1'b0;
      w_wr_mem   = 1'b0;
      w_wr_reg   = 1'b0;
      w_a_src    = c_src_zero;
      w_b_src    = c_src_zero;
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      w_illegal  = 1'b1;
      if (in_instr[1:0] == 2'b11) begin
         w_illegal = 1'b0;
         case (in_instr[6:2])
            c_op_load:   begin w_rd_mem = 1'b1; w_wr_reg = 1'b1; w_a_src = c_src_reg;
                               w_b_src = c_src_imm12; w_uses_rs1 = 1'b1; end
            c_op_fence:  ;
            c_op_imm:    begin w_wr_reg = 1'b1; w_a_src = c_src_reg; w_b_src = c_src_imm12;
                               w_uses_rs1 = 1'b1; end
            c_op_auipc:  begin w_wr_reg = 1'b1; w_a_src = c_src_pc; w_b_src = c_src_imm20; end
            c_op_store:  begin w_wr_mem = 1'b1; w_a_src = c_src_reg; w_b_src = c_src_imm12;
                               w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            c_op_op:     begin w_wr_reg = 1'b1; w_a_src = c_src_reg; w_b_src = c_src_reg;
                               w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            c_op_lui:    begin w_wr_reg = 1'b1; w_b_src = c_src_imm20; end
            c_op_branch: begin w_a_src = c_src_reg; w_b_src = c_src_reg;
                               w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            c_op_jalr:   begin w_wr_reg = 1'b1; w_a_src = c_src_pc; w_b_src = c_src_four;
                               w_uses_rs1 = 1'b1; end
            c_op_jal:    begin w_wr_reg = 1'b1; w_a_src = c_src_pc; w_b_src = c_src_four; end
            default:     w_illegal = 1'b1;
         endcase
      end
   end

   // A writeback retiring the same register this cycle resolves the hazard (write-before-read RF).
   assign w_rs1_hz = w_uses_rs1 && (w_rs1 != '0) && r_pending[w_rs1] && !(wb_valid && (wb_rd_addr == w_rs1));
   assign w_rs2_hz = w_uses_rs2 && (w_rs2 != '0) && r_pending[w_rs2] && !(wb_valid && (wb_rd_addr == w_rs2));
   assign w_hazard = in_valid && (w_rs1_hz || w_rs2_hz);
   assign in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
   assign w_load   = in_valid && in_ready;

   always_comb begin
      w_pending_nxt = r_pending;
      if (wb_valid) w_pending_nxt[wb_rd_addr] = 1'b0;
      if (w_load && w_wr_reg) w_pending_nxt[w_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending     <= '0;
         r_stall_count <= '0;
      end else begin
         r_pending <= flush ? '0 : w_pending_nxt;
         if (w_hazard && !flush && (r_stall_count != '1))
            r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_instr     <= '0;
         r_pc        <= '0;
         r_rd_mem    <= 1'b0;
         r_wr_mem    <= 1'b0;
         r_wr_reg    <= 1'b0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_a_src     <= '0;
         r_b_src     <= '0;
         r_illegal   <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_instr     <= in_instr;
         r_pc        <= in_pc;
         r_rd_mem    <= w_rd_mem;
         r_wr_mem    <= w_wr_mem;
         r_wr_reg    <= w_wr_reg;
         r_rs1       <= w_rs1;
         r_rs2       <= w_rs2;
         r_rd        <= w_rd;
         r_a_src     <= w_a_src;
         r_b_src     <= w_b_src;
         r_illegal   <= w_illegal;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid            = r_out_valid;
   assign out_instr            = r_instr;
   assign out_pc               = r_pc;
   assign out_should_read_mem  = r_rd_mem;
   assign out_should_write_mem = r_wr_mem;
   assign out_should_write_reg = r_wr_reg;
   assign out_rs1_addr         = r_rs1;
   assign out_rs2_addr         = r_rs2;
   assign out_rd_addr          = r_rd;
   assign out_alu_a_src        = r_a_src;
   assign out_alu_b_src        = r_b_src;
   assign out_illegal          = r_illegal;
   assign stall_count          = r_stall_count;
endmodule
`default_nettype wire
